instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Upstream neighbour of the datapath controller. Holds the PC and issues requests to instruction memory over a ready-handshake interface. Owns the IF/ID pipeline register, which drives OpCode and the full instruction word to decode. Handles stall from the hazard logic, branch redirect and flush, and parks one returning instruction in a skid buffer when decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted on flush or bubble (OpCode 000000).

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  synchronous, active-high reset.
Stall  in  1  decode not consuming IF/ID this cycle.
BranchTaken  in  1  redirect request from a later stage.
BranchTarget  in  32  redirect PC, word aligned.
ImemReq  out  1  instruction fetch request.
ImemAddr  out  32  fetch address; stable while ImemReq=1 and ImemRdy=0.
ImemRdy  in  1  memory returns ImemData this cycle for the current request.
ImemData  in  32  instruction word.
Instr  out  32  IF/ID instruction.
OpCode  out  6  Instr[31:26], feeds the datapath controller.
PcPlus4  out  32  IF/ID PC+4 of Instr.
InstrValid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (Rst=1 at edge): state=IDLE, PC=RESET_PC, Instr=NOP_WORD, PcPlus4=0, InstrValid=0, skid empty, RedirPc=0. ImemReq=0 while in IDLE.
- ImemAddr is PC in FETCH and KILL.
- ImemReq=1 in FETCH and KILL; 0 in IDLE and HOLD. All registered state; ImemReq and ImemAddr decode from state and PC only.
- "Accept" means IF/ID is free or being consumed: !InstrValid || !Stall.
- IDLE -> FETCH next cycle. If BranchTaken=1, PC<=BranchTarget.
- FETCH, BranchTaken=1: IF/ID <= NOP_WORD with InstrValid=0; skid cleared.
  - ImemRdy=1: drop the data, PC<=BranchTarget, stay in FETCH.
  - ImemRdy=0: RedirPc<=BranchTarget, go to KILL.
- FETCH, ImemRdy=1 and accept: Instr<=ImemData, PcPlus4<=PC+4, InstrValid<=1, PC<=PC+4. Fetch latency is 1 cycle after Rdy. Back-to-back Rdy gives one instruction per cycle.
- FETCH, ImemRdy=1 and !accept: skid<=ImemData with PC+4, PC<=PC+4, go to HOLD.
- FETCH, ImemRdy=0 and !Stall: InstrValid<=0, Instr<=NOP_WORD (bubble).
- KILL: the old request stays asserted until ImemRdy; its data is never written.
  - ImemRdy=1: PC<=RedirPc, or BranchTarget if BranchTaken is also 1. Go to FETCH.
  - BranchTaken=1 with ImemRdy=0: RedirPc<=BranchTarget (latest target wins).
  - IF/ID shows a bubble while in KILL.
- HOLD:
  - BranchTaken=1: flush IF/ID and skid, PC<=BranchTarget, go to FETCH.
  - Else Stall=0: IF/ID<=skid (InstrValid=1), skid cleared, go to FETCH.
  - Else: hold everything.
- Priority: Rst > BranchTaken > Stall > ImemRdy.
- IF/ID is never overwritten while InstrValid=1 and Stall=1.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. BranchTarget[1:0] is ignored and forced to 0.
- Reset mid-request: the in-flight response is dropped. Memory must tolerate ImemReq falling before Rdy (team memory contract).

Decomposition:
- Shared package cpu_pkg: state encoding (IDLE, FETCH, KILL, HOLD), NOP_WORD, OPCODE_MSB/LSB constants, and the instruction-word width used by the datapath controller.
- One natural sub-module: if_id_register. It holds Instr, PcPlus4 and InstrValid, and has load, flush and hold controls.
- The FSM, PC and skid buffer stay in the top block.

Test Plan:
- Reset, then ImemRdy=1 every cycle with data 0x2409_0005, 0x3129_00FF -> ImemAddr 0x0, 0x4. Instr shows each word one cycle after its Rdy. OpCode 001001 then 001100. PcPlus4 0x4, 0x8.
- Stall=1 for 3 cycles with IF/ID valid while Rdy returns 0x3529_0001 -> IF/ID unchanged, ImemReq=0 in HOLD. On Stall=0, Instr=0x3529_0001 and ImemAddr advances by 4.
- Rdy held low 2 cycles, BranchTaken=1 with target 0x40 in the 1st -> ImemAddr stays at the old PC until Rdy, that data is dropped, next ImemAddr=0x40, InstrValid=0 throughout.
- BranchTaken=1 to 0x100 in the same cycle as Rdy -> data dropped, next ImemAddr=0x100, no KILL cycle.
- PC at 0xFFFF_FFFC with Rdy -> next ImemAddr=0x0000_0000, PcPlus4=0.
- Rst pulsed during KILL and during HOLD -> next cycle all outputs at reset values, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the fetch stage and the
//            datapath controller (state encoding, instruction layout).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction word width seen by decode and the datapath controller
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Word inserted on flush or bubble; decodes as OpCode 000000
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Redirect targets are word addresses; the low two bits carry no meaning
  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module   : if_id_register
// Purpose  : IF/ID pipeline register holding the fetched instruction, its
//            PC+4 and a valid flag. Flush beats hold, hold beats load.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_register
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load,
  input  logic               flush,
  input  logic               hold,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [31:0]        load_pc_plus4,
  output logic [INSTR_W-1:0] Instr,
  output logic [31:0]        PcPlus4,
  output logic               InstrValid
);

  // Pipeline register update: reset, then flush to a bubble, then load unless held
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Instr      <= NOP_WORD;
      PcPlus4    <= 32'h0;
      InstrValid <= 1'b0;
    end else if (flush) begin
      Instr      <= NOP_WORD;
      InstrValid <= 1'b0;
    end else if (load && !hold) begin
      Instr      <= load_instr;
      PcPlus4    <= load_pc_plus4;
      InstrValid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_stage
// Purpose  : Holds the PC, issues instruction-memory requests over a ready
//            handshake, owns the IF/ID register and a one-entry skid buffer,
//            and handles stall, branch redirect and flush.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRdy,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [31:0] PcPlus4,
  output logic        InstrValid
);

  import cpu_pkg::*;

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [31:0]        redir_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc_plus4;
  logic               skid_valid;

  logic [31:0]        branch_target;
  logic [31:0]        pc_plus4;
  logic               accept;

  logic               ifid_load;
  logic               ifid_flush;
  logic               ifid_hold;
  logic [INSTR_W-1:0] ifid_instr;
  logic [31:0]        ifid_pc_plus4;

  assign branch_target = align_word(BranchTarget);
  assign pc_plus4      = pc + 32'd4;
  // IF/ID can take a new word when it is empty or decode is consuming it
  assign accept        = !InstrValid || !Stall;
  assign ifid_hold     = InstrValid && Stall;

  // Request side depends only on registered state, never on this cycle's inputs
  assign ImemReq  = (state == FETCH) || (state == KILL);
  assign ImemAddr = pc;
  assign OpCode   = Instr[OPCODE_MSB:OPCODE_LSB];

  // IF/ID control: decide whether to load memory/skid data or insert a bubble
  always_comb begin
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr    = ImemData;
    ifid_pc_plus4 = pc_plus4;
    case (state)
      FETCH: begin
        if (BranchTaken) begin
          ifid_flush = 1'b1;
        end else if (ImemRdy) begin
          ifid_load = accept;
        end else if (!Stall) begin
          ifid_flush = 1'b1;
        end
      end
      KILL: begin
        // The killed response never reaches decode
        ifid_flush = 1'b1;
      end
      HOLD: begin
        if (BranchTaken) begin
          ifid_flush = 1'b1;
        end else if (!Stall) begin
          ifid_load     = skid_valid;
          ifid_instr    = skid_instr;
          ifid_pc_plus4 = skid_pc_plus4;
        end
      end
      default: begin
      end
    endcase
  end

  // Fetch sequencer: PC, redirect target and skid buffer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      redir_pc      <= 32'h0;
      skid_instr    <= NOP_WORD;
      skid_pc_plus4 <= 32'h0;
      skid_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (BranchTaken) pc <= branch_target;
        end
        FETCH: begin
          if (BranchTaken) begin
            skid_valid <= 1'b0;
            if (ImemRdy) begin
              // Response arrives with the redirect: drop it and refetch at once
              pc <= branch_target;
            end else begin
              // Request is still outstanding; wait it out before redirecting
              redir_pc <= branch_target;
              state    <= KILL;
            end
          end else if (ImemRdy) begin
            pc <= pc_plus4;
            if (!accept) begin
              skid_instr    <= ImemData;
              skid_pc_plus4 <= pc_plus4;
              skid_valid    <= 1'b1;
              state         <= HOLD;
            end
          end
        end
        KILL: begin
          if (ImemRdy) begin
            pc    <= BranchTaken ? branch_target : redir_pc;
            state <= FETCH;
          end else if (BranchTaken) begin
            redir_pc <= branch_target;
          end
        end
        HOLD: begin
          if (BranchTaken) begin
            skid_valid <= 1'b0;
            pc         <= branch_target;
            state      <= FETCH;
          end else if (!Stall) begin
            skid_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .Clk           (Clk),
    .Rst           (Rst),
    .load          (ifid_load),
    .flush         (ifid_flush),
    .hold          (ifid_hold),
    .load_instr    (ifid_instr),
    .load_pc_plus4 (ifid_pc_plus4),
    .Instr         (Instr),
    .PcPlus4       (PcPlus4),
    .InstrValid    (InstrValid)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Purpose  : Directed self-checking bench for instruction_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemRdy = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [31:0] PcPlus4;
  logic        InstrValid;

  int tests  = 0;
  int failed = 0;

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemRdy      (ImemRdy),
    .ImemData     (ImemData),
    .Instr        (Instr),
    .OpCode       (OpCode),
    .PcPlus4      (PcPlus4),
    .InstrValid   (InstrValid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // One clock, then settle away from the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    if ({ImemReq, InstrValid, Instr, PcPlus4, OpCode} !== {1'b0, 1'b0, 32'h0, 32'h0, 6'h0}) begin
      $display("FAIL reset_values: req=%b valid=%b instr=%h pc4=%h op=%b, want 0 0 0 0 0",
               ImemReq, InstrValid, Instr, PcPlus4, OpCode);
      failed++;
    end
    tests++;
    Rst = 1'b0;
    tick();
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      $display("FAIL first_fetch: req=%b addr=%h, want 1 00000000", ImemReq, ImemAddr);
      failed++;
    end
    tests++;
  endtask

  task automatic test_back_to_back();
    ImemRdy = 1'b1; ImemData = 32'h2409_0005;
    tick();
    if ({Instr, OpCode, PcPlus4, InstrValid, ImemAddr} !== {32'h2409_0005, 6'b001001, 32'h4, 1'b1, 32'h4}) begin
      $display("FAIL b2b_word0: instr=%h op=%b pc4=%h valid=%b addr=%h, want 24090005 001001 4 1 4",
               Instr, OpCode, PcPlus4, InstrValid, ImemAddr);
      failed++;
    end
    tests++;
    ImemData = 32'h3129_00FF;
    tick();
    if ({Instr, OpCode, PcPlus4, InstrValid, ImemAddr} !== {32'h3129_00FF, 6'b001100, 32'h8, 1'b1, 32'h8}) begin
      $display("FAIL b2b_word1: instr=%h op=%b pc4=%h valid=%b addr=%h, want 312900ff 001100 8 1 8",
               Instr, OpCode, PcPlus4, InstrValid, ImemAddr);
      failed++;
    end
    tests++;
    ImemRdy = 1'b0;
    tick();
    if ({InstrValid, Instr, ImemReq, ImemAddr} !== {1'b0, 32'h0, 1'b1, 32'h8}) begin
      $display("FAIL bubble: valid=%b instr=%h req=%b addr=%h, want 0 0 1 8",
               InstrValid, Instr, ImemReq, ImemAddr);
      failed++;
    end
    tests++;
  endtask

  task automatic test_stall_skid();
    ImemRdy = 1'b1; ImemData = 32'h3C01_0001;
    tick();
    if ({Instr, PcPlus4, InstrValid, ImemAddr} !== {32'h3C01_0001, 32'hC, 1'b1, 32'hC}) begin
      $display("FAIL stall_setup: instr=%h pc4=%h valid=%b addr=%h, want 3c010001 c 1 c",
               Instr, PcPlus4, InstrValid, ImemAddr);
      failed++;
    end
    tests++;
    Stall = 1'b1; ImemData = 32'h3529_0001;
    tick();
    ImemRdy = 1'b0;
    if ({Instr, InstrValid, ImemReq} !== {32'h3C01_0001, 1'b1, 1'b0}) begin
      $display("FAIL stall_hold1: instr=%h valid=%b req=%b, want 3c010001 1 0", Instr, InstrValid, ImemReq);
      failed++;
    end
    tests++;
    tick();
    tick();
    if ({Instr, InstrValid, ImemReq} !== {32'h3C01_0001, 1'b1, 1'b0}) begin
      $display("FAIL stall_hold3: instr=%h valid=%b req=%b, want 3c010001 1 0", Instr, InstrValid, ImemReq);
      failed++;
    end
    tests++;
    Stall = 1'b0;
    tick();
    if ({Instr, PcPlus4, InstrValid, ImemReq, ImemAddr} !== {32'h3529_0001, 32'h10, 1'b1, 1'b1, 32'h10}) begin
      $display("FAIL skid_release: instr=%h pc4=%h valid=%b req=%b addr=%h, want 35290001 10 1 1 10",
               Instr, PcPlus4, InstrValid, ImemReq, ImemAddr);
      failed++;
    end
    tests++;
  endtask

  task automatic test_kill();
    ImemRdy = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h40;
    tick();
    BranchTaken = 1'b0;
    if ({ImemReq, ImemAddr, InstrValid, Instr} !== {1'b1, 32'h10, 1'b0, 32'h0}) begin
      $display("FAIL kill_cycle1: req=%b addr=%h valid=%b instr=%h, want 1 10 0 0",
               ImemReq, ImemAddr, InstrValid, Instr);
      failed++;
    end
    tests++;
    tick();
    if ({ImemReq, ImemAddr, InstrValid} !== {1'b1, 32'h10, 1'b0}) begin
      $display("FAIL kill_cycle2: req=%b addr=%h valid=%b, want 1 10 0", ImemReq, ImemAddr, InstrValid);
      failed++;
    end
    tests++;
    ImemRdy = 1'b1; ImemData = 32'hDEAD_BEEF;
    tick();
    ImemRdy = 1'b0;
    if ({ImemReq, ImemAddr, InstrValid, Instr} !== {1'b1, 32'h40, 1'b0, 32'h0}) begin
      $display("FAIL kill_redirect: req=%b addr=%h valid=%b instr=%h, want 1 40 0 0",
               ImemReq, ImemAddr, InstrValid, Instr);
      failed++;
    end
    tests++;
  endtask

  task automatic test_branch_with_rdy();
    ImemRdy = 1'b1; ImemData = 32'h1111_1111; BranchTaken = 1'b1; BranchTarget = 32'h103;
    tick();
    BranchTaken = 1'b0;
    if ({ImemReq, ImemAddr, InstrValid} !== {1'b1, 32'h100, 1'b0}) begin
      $display("FAIL branch_rdy: req=%b addr=%h valid=%b, want 1 100 0", ImemReq, ImemAddr, InstrValid);
      failed++;
    end
    tests++;
    ImemData = 32'h2042_0007;
    tick();
    if ({Instr, PcPlus4, InstrValid} !== {32'h2042_0007, 32'h104, 1'b1}) begin
      $display("FAIL branch_no_kill: instr=%h pc4=%h valid=%b, want 20420007 104 1",
               Instr, PcPlus4, InstrValid);
      failed++;
    end
    tests++;
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC; ImemRdy = 1'b1;
    tick();
    BranchTaken = 1'b0;
    if (ImemAddr !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_setup: addr=%h, want fffffffc", ImemAddr);
      failed++;
    end
    tests++;
    ImemData = 32'h8C22_0000;
    tick();
    ImemRdy = 1'b0;
    if ({ImemAddr, PcPlus4, Instr, OpCode} !== {32'h0, 32'h0, 32'h8C22_0000, 6'b100011}) begin
      $display("FAIL wrap: addr=%h pc4=%h instr=%h op=%b, want 0 0 8c220000 100011",
               ImemAddr, PcPlus4, Instr, OpCode);
      failed++;
    end
    tests++;
    tick();
  endtask

  task automatic test_reset_in_kill();
    BranchTaken = 1'b1; BranchTarget = 32'h200; ImemRdy = 1'b0;
    tick();
    BranchTaken = 1'b0;
    Rst = 1'b1;
    tick();
    if ({ImemReq, ImemAddr, InstrValid, Instr, PcPlus4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      $display("FAIL reset_kill: req=%b addr=%h valid=%b instr=%h pc4=%h, want 0 0 0 0 0",
               ImemReq, ImemAddr, InstrValid, Instr, PcPlus4);
      failed++;
    end
    tests++;
    Rst = 1'b0;
    tick();
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      $display("FAIL reset_kill_restart: req=%b addr=%h, want 1 0", ImemReq, ImemAddr);
      failed++;
    end
    tests++;
    ImemRdy = 1'b1; ImemData = 32'h3C08_0123;
    tick();
    ImemRdy = 1'b0;
    if ({Instr, PcPlus4, InstrValid} !== {32'h3C08_0123, 32'h4, 1'b1}) begin
      $display("FAIL reset_kill_fetch: instr=%h pc4=%h valid=%b, want 3c080123 4 1",
               Instr, PcPlus4, InstrValid);
      failed++;
    end
    tests++;
  endtask

  task automatic test_reset_in_hold();
    Stall = 1'b1; ImemRdy = 1'b1; ImemData = 32'h0109_5020;
    tick();
    if ({ImemReq, Instr} !== {1'b0, 32'h3C08_0123}) begin
      $display("FAIL hold_setup: req=%b instr=%h, want 0 3c080123", ImemReq, Instr);
      failed++;
    end
    tests++;
    Rst = 1'b1; Stall = 1'b0; ImemRdy = 1'b0;
    tick();
    if ({ImemReq, ImemAddr, InstrValid, Instr, PcPlus4} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      $display("FAIL reset_hold: req=%b addr=%h valid=%b instr=%h pc4=%h, want 0 0 0 0 0",
               ImemReq, ImemAddr, InstrValid, Instr, PcPlus4);
      failed++;
    end
    tests++;
    Rst = 1'b0;
    tick();
    tick();
    if ({ImemReq, ImemAddr, InstrValid} !== {1'b1, 32'h0, 1'b0}) begin
      $display("FAIL reset_hold_skid_empty: req=%b addr=%h valid=%b, want 1 0 0",
               ImemReq, ImemAddr, InstrValid);
      failed++;
    end
    tests++;
    ImemRdy = 1'b1; ImemData = 32'h2409_0005;
    tick();
    ImemRdy = 1'b0;
    if ({Instr, PcPlus4, InstrValid} !== {32'h2409_0005, 32'h4, 1'b1}) begin
      $display("FAIL reset_hold_fetch: instr=%h pc4=%h valid=%b, want 24090005 4 1",
               Instr, PcPlus4, InstrValid);
      failed++;
    end
    tests++;
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_stall_skid();
    test_kill();
    test_branch_with_rdy();
    test_wrap();
    test_reset_in_kill();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
